// File: rtl/lagd_spi_host_master.sv
// SPI host master: serialises one word access per frame (cmd, address, dummy, data).
// Define LAGD_SPI_QUAD_EN to run the DATA phase four bits per SCK on sd[3:0].
module lagd_spi_host_master #(
  parameter int unsigned ClkDiv       = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned DummyCycles  = 8,
  parameter int unsigned CsIdleCycles = 2,
  parameter logic [7:0]  CmdWrite     = 8'h02,
  parameter logic [7:0]  CmdRead      = 8'h0B
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 busy_o,
  output logic                 spi_sck_o,
  output logic                 spi_csb_o,
  output logic [3:0]           spi_sd_o,
  output logic [3:0]           spi_sd_oe_o,
  input  logic [3:0]           spi_sd_i
);

`ifdef LAGD_SPI_QUAD_EN
  localparam bit QuadEn = 1'b1;
`else
  localparam bit QuadEn = 1'b0;
`endif

  localparam int unsigned DataBeats = QuadEn ? DataWidth / 4 : DataWidth;
  localparam int unsigned MaxAD     = (AddrWidth > DataWidth) ? AddrWidth : DataWidth;
  localparam int unsigned MaxAD8    = (MaxAD > 8) ? MaxAD : 8;
  localparam int unsigned MaxLen    = (MaxAD8 > DummyCycles) ? MaxAD8 : DummyCycles;
  localparam int unsigned CntW      = $clog2(MaxLen + 1);
  localparam int unsigned DivW      = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
  // The RSP and IDLE cycles already keep csb high for two clocks, so GAP
  // only has to cover whatever idle time is required beyond that.
  localparam int unsigned GapCycles = (CsIdleCycles > 2) ? CsIdleCycles - 2 : 0;
  localparam int unsigned GapW      = $clog2(CsIdleCycles + 1);
  localparam int unsigned TxW       = 8 + AddrWidth + DataWidth;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5,
    S_RSP   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DivW-1:0]     r_div;
  logic                r_sck;
  logic [CntW-1:0]     r_bit_cnt;
  logic [GapW-1:0]     r_gap_cnt;
  logic                r_write;
  logic [TxW-1:0]      r_tx;
  logic [DataWidth-1:0] r_rx;

  logic w_shifting;
  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_phase_done;
  logic w_accept;

  function automatic logic [CntW-1:0] phase_len(input state_t s);
    case (s)
      S_CMD:   return CntW'(8);
      S_ADDR:  return CntW'(AddrWidth);
      S_DUMMY: return CntW'(DummyCycles);
      S_DATA:  return CntW'(DataBeats);
      default: return '0;
    endcase
  endfunction

  assign w_shifting   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_tick       = w_shifting && (r_div == DivLast);
  assign w_rise       = w_tick && !r_sck;
  assign w_fall       = w_tick && r_sck;
  assign w_phase_done = w_fall && (r_bit_cnt == CntW'(1));
  assign w_accept     = (r_state == S_IDLE) && req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid_i) w_state_nxt = S_CMD;
      S_CMD:   if (w_phase_done) w_state_nxt = S_ADDR;
      S_ADDR:  if (w_phase_done) w_state_nxt = (r_write || (DummyCycles == 0)) ? S_DATA : S_DUMMY;
      S_DUMMY: if (w_phase_done) w_state_nxt = S_DATA;
      S_DATA:  if (w_phase_done) w_state_nxt = (GapCycles == 0) ? S_RSP : S_GAP;
      S_GAP:   if (r_gap_cnt == GapW'(1)) w_state_nxt = S_RSP;
      S_RSP:   if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SCK divider, per-phase bit counter and gap counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div     <= '0;
      r_sck     <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_write   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write_i;
      end
      if (!w_shifting) begin
        r_div <= '0;
        r_sck <= 1'b0;
      end else if (w_tick) begin
        r_div <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + DivW'(1);
      end
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= phase_len(w_state_nxt);
      end else if (w_fall) begin
        r_bit_cnt <= r_bit_cnt - CntW'(1);
      end
      if ((w_state_nxt == S_GAP) && (r_state != S_GAP)) begin
        r_gap_cnt <= GapW'(GapCycles);
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - GapW'(1);
      end
    end
  end

  // Whole frame sits in one shift register; DUMMY just holds it in place.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_tx <= {(req_write_i ? CmdWrite : CmdRead), req_addr_i, req_wdata_i};
    end else if (w_fall && (r_state != S_DUMMY)) begin
      r_tx <= (QuadEn && (r_state == S_DATA)) ? (r_tx << 4) : (r_tx << 1);
    end
    if (w_rise && (r_state == S_DATA) && !r_write) begin
      r_rx <= QuadEn ? {r_rx[DataWidth-5:0], spi_sd_i} : {r_rx[DataWidth-2:0], spi_sd_i[1]};
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    busy_o      = (r_state != S_IDLE);
    spi_csb_o   = 1'b1;
    spi_sd_o    = 4'b0000;
    spi_sd_oe_o = 4'b0000;
    case (r_state)
      S_IDLE: req_ready_o = 1'b1;
      S_CMD, S_ADDR: begin
        spi_csb_o   = 1'b0;
        spi_sd_oe_o = 4'b0001;
        spi_sd_o    = {3'b000, r_tx[TxW-1]};
      end
      S_DUMMY: spi_csb_o = 1'b0;
      S_DATA: begin
        spi_csb_o = 1'b0;
        if (r_write) begin
          if (QuadEn) begin
            spi_sd_oe_o = 4'b1111;
            spi_sd_o    = r_tx[TxW-1 -: 4];
          end else begin
            spi_sd_oe_o = 4'b0001;
            spi_sd_o    = {3'b000, r_tx[TxW-1]};
          end
        end
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = r_write ? '0 : r_rx;
      end
      default: ;
    endcase
  end

  assign spi_sck_o = r_sck;

endmodule

// File: tb/tb_lagd_spi_host_master.sv
// Scoreboard bench for lagd_spi_host_master with an SPI target model and random traffic.
`timescale 1ns/1ps
module tb_lagd_spi_host_master;
  localparam int CLK_DIV = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DC      = 8;
  localparam int CSI     = 2;
`ifdef LAGD_SPI_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  localparam int DATA_EDGES = QUAD ? DW / 4 : DW;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          busy_o;
  logic          spi_sck_o;
  logic          spi_csb_o;
  logic [3:0]    spi_sd_o;
  logic [3:0]    spi_sd_oe_o;
  logic [3:0]    spi_sd_i;

  frame_t      q_frame[$];
  logic [31:0] q_rsp[$];
  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 1;
  bit b2b = 1'b0;

  // frame monitor state
  bit prev_sck, prev_csb, have_end, cur_wr, oe_bad, rdy_bad;
  int edges, low_clks, hi_clks;
  logic [7:0]  cap_cmd;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  bit hold_prev;
  logic [DW-1:0] held;

  always #5 clk = ~clk;

  lagd_spi_host_master #(
    .ClkDiv(CLK_DIV), .AddrWidth(AW), .DataWidth(DW), .DummyCycles(DC),
    .CsIdleCycles(CSI), .CmdWrite(8'h02), .CmdRead(8'h0B)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .busy_o(busy_o), .spi_sck_o(spi_sck_o), .spi_csb_o(spi_csb_o),
    .spi_sd_o(spi_sd_o), .spi_sd_oe_o(spi_sd_oe_o), .spi_sd_i(spi_sd_i)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame monitor: watches the pins and rebuilds cmd/addr/data from rising SCK edges.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_sck = 1'b0;
      prev_csb = 1'b1;
      have_end = 1'b0;
      edges    = 0;
    end else begin
      if (prev_csb && !spi_csb_o) begin
        if (have_end) begin
          if (b2b) chk("cs_gap_exact", hi_clks, CSI);
          else     chk("cs_gap_min", (hi_clks >= CSI), 1);
        end
        chk("frame_pending", (q_frame.size() > 0), 1);
        cur_wr = (q_frame.size() > 0) ? q_frame[0].wr : 1'b0;
        edges = 0; low_clks = 0; oe_bad = 0; rdy_bad = 0;
        cap_cmd = '0; cap_addr = '0; cap_data = '0;
      end
      if (!spi_csb_o) begin
        logic [3:0] exp_oe;
        low_clks++;
        if (req_ready_o || !busy_o) rdy_bad = 1'b1;
        if (!prev_sck && spi_sck_o) begin
          if (edges < 8 + AW)  exp_oe = 4'b0001;
          else if (!cur_wr)    exp_oe = 4'b0000;
          else                 exp_oe = QUAD ? 4'b1111 : 4'b0001;
          if (spi_sd_oe_o !== exp_oe) oe_bad = 1'b1;
          if (edges < 8)                    cap_cmd  = {cap_cmd[6:0], spi_sd_o[0]};
          else if (edges < 8 + AW)          cap_addr = {cap_addr[AW-2:0], spi_sd_o[0]};
          else if (cur_wr && QUAD)          cap_data = {cap_data[DW-5:0], spi_sd_o};
          else if (cur_wr)                  cap_data = {cap_data[DW-2:0], spi_sd_o[0]};
          edges++;
        end
      end else if (!prev_csb) begin
        if (q_frame.size() > 0) begin
          frame_t f;
          int exp_edges;
          f = q_frame.pop_front();
          exp_edges = 8 + AW + (f.wr ? 0 : DC) + DATA_EDGES;
          chk("rising_edges", edges, exp_edges);
          chk("csb_low_clks", low_clks, exp_edges * 2 * CLK_DIV);
          chk("cmd_byte", cap_cmd, f.wr ? 8'h02 : 8'h0B);
          chk("addr", cap_addr, f.addr);
          if (f.wr) chk("wdata", cap_data, f.wdata);
          chk("oe_pattern_ok", oe_bad, 0);
          chk("ready_low_busy_high", rdy_bad, 0);
          chk("sck_low_at_csb_rise", spi_sck_o, 0);
        end
        have_end = 1'b1;
        hi_clks  = 1;
      end else begin
        hi_clks++;
      end
      prev_sck = spi_sck_o;
      prev_csb = spi_csb_o;
    end
  end

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (rst_i) begin
      hold_prev = 1'b0;
    end else if (rsp_valid_o) begin
      if (hold_prev) chk("rsp_stable", rsp_rdata_o, held);
      if (rsp_ready_i) begin
        chk("rsp_expected", (q_rsp.size() > 0), 1);
        if (q_rsp.size() > 0) chk("rsp_rdata", rsp_rdata_o, q_rsp.pop_front());
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        held = rsp_rdata_o;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // SPI target: presents read data while SCK is low, random noise elsewhere.
  initial begin
    spi_sd_i = 4'b0000;
    forever begin
      @(negedge clk); #1;
      if (!rst_i && !spi_csb_o && !spi_sck_o && (q_frame.size() > 0)) begin
        logic [31:0] rd, nz;
        int k;
        rd = q_frame[0].rdata;
        nz = $urandom;
        k  = edges - (8 + AW + DC);
        if (q_frame[0].wr || k < 0 || k >= DATA_EDGES) spi_sd_i = nz[3:0];
        else if (QUAD) spi_sd_i = rd[DW-1-4*k -: 4];
        else spi_sd_i = {nz[3:2], rd[DW-1-k], nz[0]};
      end
    end
  end

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: rsp_ready_i = ($urandom_range(0, 3) != 0);
        1: rsp_ready_i = 1'b1;
        default: rsp_ready_i = 1'b0;
      endcase
    end
  end

  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input bit keep);
    frame_t f;
    int t;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = a;
    req_wdata_i = wd;
    t = 0;
    while (!req_ready_o && t < 5000) begin @(negedge clk); t++; end
    chk("accept_wait_bound", (t < 5000), 1);
    f.wr = wr; f.addr = a; f.wdata = wd; f.rdata = rd;
    q_frame.push_back(f);
    q_rsp.push_back(wr ? 32'h0 : rd);
    @(negedge clk);
    if (!keep) req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_o || q_rsp.size() != 0) && t < 20000) begin @(negedge clk); t++; end
    chk("idle_wait_bound", (t < 20000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit bad;
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_sck", spi_sck_o, 0);
    chk("rst_csb", spi_csb_o, 1);
    chk("rst_sd", spi_sd_o, 0);
    chk("rst_sd_oe", spi_sd_oe_o, 0);
    @(negedge clk);

    rdy_mode = 1;
    send(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_idle();
    send(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b0);
    wait_idle();

    // back-to-back writes with valid held high
    send(1'b1, 32'h0000_1000, 32'h1111_2222, 32'h0, 1'b1);
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, $urandom, $urandom, 32'h0, 1'b1);
    req_valid_i = 1'b0;
    wait_idle();
    b2b = 1'b0;

    // response back-pressure
    rdy_mode = 2;
    send(1'b0, 32'h0000_0080, 32'h0, 32'h5A5A_C3C3, 1'b0);
    t = 0;
    while (!rsp_valid_o && t < 2000) begin @(negedge clk); t++; end
    chk("rsp_wait_bound", (t < 2000), 1);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!rsp_valid_o || rsp_rdata_o !== 32'h5A5A_C3C3 || req_ready_o || !spi_csb_o) bad = 1'b1;
      @(negedge clk);
    end
    chk("rsp_hold_50clk", bad, 0);
    rdy_mode = 1;
    wait_idle();

    // reset in the middle of the address phase
    send(1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32'h0, 1'b0);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (edges != 8 + 10 && t < 2000);
    chk("addr_bit_wait_bound", (t < 2000), 1);
    rst_i = 1'b1;
    #1;
    chk("abort_csb", spi_csb_o, 1);
    chk("abort_sck", spi_sck_o, 0);
    chk("abort_oe", spi_sd_oe_o, 0);
    chk("abort_sd", spi_sd_o, 0);
    chk("abort_ready_busy_rsp", {req_ready_o, busy_o, rsp_valid_o}, 3'b100);
    q_frame.delete();
    q_rsp.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", rsp_valid_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    send(1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 1'b0);
    wait_idle();

    // random traffic with random response back-pressure
    rdy_mode = 0;
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rdy_mode = 1;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queues_drained", q_frame.size() + q_rsp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
